sim_channel_retimer: RTL and testbench

Parametrised boundary retimer between the simulator tick model and the DUT top in the emulation harness. It handles a configurable number of packed-record channels, from 1 to 16, where the previous harness had a fixed set. Capture latency (DUT to simulator) is a parameter, and the simulator-to-DUT drive path is registered with a choice of hold or zero on idle cycles. It adds things the old harness lacked: a built-in DUT reset sequencer, a per-channel enable mask, a saturating tick counter, and a fin-driven drain/done handshake.

---
 rtl/sim_channel_retimer.sv | 155 +++++++++++++++
 tb/tb_sim_channel_retimer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sim_channel_retimer.sv
// Boundary retimer between the simulator tick model and the DUT top.
// Captures masked DUT records through a LATENCY-deep pipe, drives masked
// simulator records into the DUT through a register, sequences the DUT
// reset, counts RUN ticks and performs a fin-driven drain/done handshake.
// reset_i is the asynchronous, active-low harness reset.
//
// state       | meaning
// RESET_HOLD  | dut_reset_o asserted, counting RESET_CYCLES, nothing captured
// RUN         | capture and drive every cycle, tick counter running
// DRAIN       | no new captures, pipe shifting out for LATENCY cycles
// DONE        | terminal until reset, done_o high, outputs held
module sim_channel_retimer #(
    parameter int NUM_CHANNELS = 4,
    parameter int FWD_WIDTH    = 64,
    parameter int REV_WIDTH    = 64,
    parameter int LATENCY      = 1,
    parameter int RESET_CYCLES = 10,
    parameter bit HOLD_LAST    = 1'b1,
    parameter int CNT_WIDTH    = 64
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic [NUM_CHANNELS-1:0]        chan_enable_i,
    input  logic                           fin_i,
    input  logic [NUM_CHANNELS*FWD_WIDTH-1:0] dut_fwd_i,
    output logic [NUM_CHANNELS*FWD_WIDTH-1:0] sim_fwd_o,
    output logic                           sim_fwd_valid_o,
    input  logic [NUM_CHANNELS*REV_WIDTH-1:0] sim_rev_i,
    input  logic                           sim_rev_valid_i,
    output logic [NUM_CHANNELS*REV_WIDTH-1:0] dut_rev_o,
    output logic                           dut_reset_o,
    output logic [CNT_WIDTH-1:0]           tick_count_o,
    output logic [1:0]                     state_o,
    output logic                           done_o
);

    localparam int FW = NUM_CHANNELS * FWD_WIDTH;
    localparam int RW = NUM_CHANNELS * REV_WIDTH;

    // Reject unsupported configurations at elaboration.
    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16) begin : g_bad_channels
        $error("sim_channel_retimer: NUM_CHANNELS must be 1..16");
    end
    if (FWD_WIDTH < 1 || REV_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_width
        $error("sim_channel_retimer: widths must be at least 1");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("sim_channel_retimer: LATENCY must be 1..4");
    end
    if (RESET_CYCLES < 0 || RESET_CYCLES > 255) begin : g_bad_reset_cycles
        $error("sim_channel_retimer: RESET_CYCLES must be 0..255");
    end

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_RUN        = 2'd1,
        ST_DRAIN      = 2'd2,
        ST_DONE       = 2'd3
    } state_t;

    state_t                state_q;
    logic [7:0]            cnt_q;
    logic                  fin_pending_q;
    logic [CNT_WIDTH-1:0]  tick_q;
    logic [RW-1:0]         dut_rev_q;
    logic                  dut_reset_q;
    logic                  done_q;
    logic [FW-1:0]         pipe_data_q [LATENCY];
    logic [LATENCY-1:0]    pipe_valid_q;

    logic [FW-1:0]         fwd_masked_d;
    logic [RW-1:0]         rev_masked_d;
    logic                  fin_seen_d;
    logic                  hold_expired_d;

    // Zero the slices of disabled channels in both directions.
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_mask
        assign fwd_masked_d[i*FWD_WIDTH +: FWD_WIDTH] =
            chan_enable_i[i] ? dut_fwd_i[i*FWD_WIDTH +: FWD_WIDTH] : '0;
        assign rev_masked_d[i*REV_WIDTH +: REV_WIDTH] =
            chan_enable_i[i] ? sim_rev_i[i*REV_WIDTH +: REV_WIDTH] : '0;
    end

    // A fin arriving on the very edge that ends the hold still diverts to DRAIN.
    assign fin_seen_d     = fin_pending_q | fin_i;
    assign hold_expired_d = ({1'b0, cnt_q} + 9'd1) >= 9'(RESET_CYCLES);

    // Capture pipe: shifts in RESET_HOLD/RUN/DRAIN, frozen in DONE so sim_fwd_o keeps its last data.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            pipe_valid_q <= '0;
            for (int s = 0; s < LATENCY; s++) pipe_data_q[s] <= '0;
        end else if (state_q != ST_DONE) begin
            pipe_valid_q[0] <= (state_q == ST_RUN);
            if (state_q == ST_RUN) pipe_data_q[0] <= fwd_masked_d;
            for (int s = 1; s < LATENCY; s++) begin
                pipe_valid_q[s] <= pipe_valid_q[s-1];
                pipe_data_q[s]  <= pipe_data_q[s-1];
            end
        end
    end

    // Sequencer: reset hold, run-time drive and tick count, drain and done.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= ST_RESET_HOLD;
            cnt_q         <= '0;
            fin_pending_q <= 1'b0;
            tick_q        <= '0;
            dut_rev_q     <= '0;
            dut_reset_q   <= 1'b1;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_RESET_HOLD: begin
                    dut_rev_q     <= '0;
                    fin_pending_q <= fin_seen_d;
                    cnt_q         <= cnt_q + 8'd1;
                    if (hold_expired_d) begin
                        cnt_q       <= '0;
                        dut_reset_q <= 1'b0;
                        state_q     <= fin_seen_d ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tick_q != '1) tick_q <= tick_q + CNT_WIDTH'(1);
                    if (sim_rev_valid_i) dut_rev_q <= rev_masked_d;
                    else if (!HOLD_LAST) dut_rev_q <= '0;
                    if (fin_i) begin
                        cnt_q   <= '0;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == 8'(LATENCY - 1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sim_fwd_o       = pipe_data_q[LATENCY-1];
    assign sim_fwd_valid_o = pipe_valid_q[LATENCY-1];
    assign dut_rev_o       = dut_rev_q;
    assign dut_reset_o     = dut_reset_q;
    assign tick_count_o    = tick_q;
    assign state_o         = state_q;
    assign done_o          = done_q;

endmodule

// File: tb/tb_sim_channel_retimer.sv
// Bench for sim_channel_retimer: three configurations share one stimulus
// stream and are checked every cycle against a queue/array-based model.
module tb_sim_channel_retimer;

    localparam int NC = 4;
    localparam int W  = 16;
    localparam int NM = 3;

    // Per-configuration parameters: A, B, C
    localparam int LAT_A = 3, LAT_B = 1, LAT_C = 2;
    localparam int RC_A = 10, RC_B = 0, RC_C = 3;

    int               cfg_lat  [NM] = '{LAT_A, LAT_B, LAT_C};
    int               cfg_rc   [NM] = '{RC_A, RC_B, RC_C};
    bit               cfg_hold [NM] = '{1'b1, 1'b0, 1'b1};
    longint unsigned  cfg_tmax [NM] = '{64'hFF, 64'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF};

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NC-1:0]     chan_en;
    logic              fin;
    logic [NC*W-1:0]   dut_fwd;
    logic [NC*W-1:0]   sim_rev;
    logic              sim_rev_valid;

    logic [NC*W-1:0]   o_fwd   [NM];
    logic              o_val   [NM];
    logic [NC*W-1:0]   o_rev   [NM];
    logic              o_rst   [NM];
    logic [1:0]        o_state [NM];
    logic              o_done  [NM];
    logic [7:0]        tick_a;
    logic [15:0]       tick_b;
    logic [63:0]       tick_c;

    always #5 clk = ~clk;

    sim_channel_retimer #(.NUM_CHANNELS(NC), .FWD_WIDTH(W), .REV_WIDTH(W), .LATENCY(LAT_A),
        .RESET_CYCLES(RC_A), .HOLD_LAST(1'b1), .CNT_WIDTH(8)) u_dut_a (
        .clock_i(clk), .reset_i(rst_n), .chan_enable_i(chan_en), .fin_i(fin),
        .dut_fwd_i(dut_fwd), .sim_fwd_o(o_fwd[0]), .sim_fwd_valid_o(o_val[0]),
        .sim_rev_i(sim_rev), .sim_rev_valid_i(sim_rev_valid), .dut_rev_o(o_rev[0]),
        .dut_reset_o(o_rst[0]), .tick_count_o(tick_a), .state_o(o_state[0]), .done_o(o_done[0]));

    sim_channel_retimer #(.NUM_CHANNELS(NC), .FWD_WIDTH(W), .REV_WIDTH(W), .LATENCY(LAT_B),
        .RESET_CYCLES(RC_B), .HOLD_LAST(1'b0), .CNT_WIDTH(16)) u_dut_b (
        .clock_i(clk), .reset_i(rst_n), .chan_enable_i(chan_en), .fin_i(fin),
        .dut_fwd_i(dut_fwd), .sim_fwd_o(o_fwd[1]), .sim_fwd_valid_o(o_val[1]),
        .sim_rev_i(sim_rev), .sim_rev_valid_i(sim_rev_valid), .dut_rev_o(o_rev[1]),
        .dut_reset_o(o_rst[1]), .tick_count_o(tick_b), .state_o(o_state[1]), .done_o(o_done[1]));

    sim_channel_retimer #(.NUM_CHANNELS(NC), .FWD_WIDTH(W), .REV_WIDTH(W), .LATENCY(LAT_C),
        .RESET_CYCLES(RC_C), .HOLD_LAST(1'b1), .CNT_WIDTH(64)) u_dut_c (
        .clock_i(clk), .reset_i(rst_n), .chan_enable_i(chan_en), .fin_i(fin),
        .dut_fwd_i(dut_fwd), .sim_fwd_o(o_fwd[2]), .sim_fwd_valid_o(o_val[2]),
        .sim_rev_i(sim_rev), .sim_rev_valid_i(sim_rev_valid), .dut_rev_o(o_rev[2]),
        .dut_reset_o(o_rst[2]), .tick_count_o(tick_c), .state_o(o_state[2]), .done_o(o_done[2]));

    // ---------------- reference model ----------------
    localparam int PH_HOLD = 0, PH_RUN = 1, PH_DRAIN = 2, PH_DONE = 3;

    int              m_phase [NM];
    int              m_hcnt  [NM];
    bit              m_fin   [NM];
    longint unsigned m_tick  [NM];
    int              m_drain [NM];
    logic [63:0]     m_rev   [NM];
    logic [63:0]     m_cap   [NM];
    bit              ring_v  [NM][8];
    logic [63:0]     ring_d  [NM][8];
    int              wp      [NM];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [63:0] apply_mask(input logic [NC-1:0] en, input logic [63:0] d);
        logic [63:0] r;
        r = d;
        for (int c = 0; c < NC; c++)
            if (!en[c]) r[c*W +: W] = '0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int m = 0; m < NM; m++) begin
            m_phase[m] = PH_HOLD; m_hcnt[m] = 0; m_fin[m] = 0; m_tick[m] = 0;
            m_drain[m] = 0; m_rev[m] = '0; m_cap[m] = '0; wp[m] = 0;
            for (int k = 0; k < 8; k++) begin ring_v[m][k] = 0; ring_d[m][k] = '0; end
        end
    endtask

    task automatic push(input int m, input bit v);
        ring_v[m][wp[m]] = v;
        ring_d[m][wp[m]] = m_cap[m];
        wp[m] = (wp[m] + 1) % 8;
    endtask

    // One clock edge of the specified behaviour, using the inputs held across it.
    task automatic model_edge();
        if (!rst_n) return;
        for (int m = 0; m < NM; m++) begin
            case (m_phase[m])
                PH_HOLD: begin
                    push(m, 0);
                    m_hcnt[m]++;
                    if (fin) m_fin[m] = 1;
                    if (m_hcnt[m] >= cfg_rc[m]) begin
                        if (m_fin[m]) begin m_phase[m] = PH_DRAIN; m_drain[m] = cfg_lat[m]; end
                        else m_phase[m] = PH_RUN;
                    end
                end
                PH_RUN: begin
                    m_cap[m] = apply_mask(chan_en, dut_fwd);
                    push(m, 1);
                    if (m_tick[m] < cfg_tmax[m]) m_tick[m]++;
                    if (sim_rev_valid) m_rev[m] = apply_mask(chan_en, sim_rev);
                    else if (!cfg_hold[m]) m_rev[m] = '0;
                    if (fin) begin m_phase[m] = PH_DRAIN; m_drain[m] = cfg_lat[m]; end
                end
                PH_DRAIN: begin
                    push(m, 0);
                    m_drain[m]--;
                    if (m_drain[m] == 0) m_phase[m] = PH_DONE;
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        logic [63:0] tk [NM];
        int idx;
        tk[0] = {56'b0, tick_a};
        tk[1] = {48'b0, tick_b};
        tk[2] = tick_c;
        for (int m = 0; m < NM; m++) begin
            idx = (wp[m] + 8 - cfg_lat[m]) % 8;
            chk($sformatf("cfg%0d state", m), 64'(o_state[m]), 64'(m_phase[m]));
            chk($sformatf("cfg%0d done", m), 64'(o_done[m]), 64'(m_phase[m] == PH_DONE));
            chk($sformatf("cfg%0d dut_reset", m), 64'(o_rst[m]), 64'(m_phase[m] == PH_HOLD));
            chk($sformatf("cfg%0d sim_fwd_valid", m), 64'(o_val[m]), 64'(ring_v[m][idx]));
            chk($sformatf("cfg%0d sim_fwd", m), o_fwd[m], ring_d[m][idx]);
            chk($sformatf("cfg%0d dut_rev", m), o_rev[m], m_rev[m]);
            chk($sformatf("cfg%0d tick_count", m), tk[m], 64'(m_tick[m]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    task automatic rand_inputs();
        chan_en       = 4'($urandom);
        dut_fwd       = {$urandom, $urandom};
        sim_rev       = {$urandom, $urandom};
        sim_rev_valid = 1'($urandom);
        fin           = 1'b0;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        step();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        chan_en = '1; fin = 1'b0; dut_fwd = '0; sim_rev = '0; sim_rev_valid = 1'b0;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // Reset hold and first RUN cycles under random traffic
        for (int i = 0; i < 14; i++) begin rand_inputs(); step(); end

        // Ramp with all channels enabled
        chan_en = '1; sim_rev_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            dut_fwd = {4{16'(k)}};
            step();
        end

        // Mask and hold on the drive path
        chan_en = 4'b1010; sim_rev = '1; sim_rev_valid = 1'b1;
        step();
        sim_rev_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin sim_rev = {$urandom, $urandom}; step(); end

        for (int i = 0; i < 20; i++) begin rand_inputs(); step(); end

        // Async reset mid-RUN, then a long run to saturate the 8-bit counter
        async_reset();
        for (int i = 0; i < 280; i++) begin rand_inputs(); step(); end

        // Fin together with a valid drive, then drain and done
        rand_inputs(); sim_rev_valid = 1'b1; fin = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin rand_inputs(); step(); end

        // Fin in RUN cycle 5 of configuration C after a fresh reset
        async_reset();
        for (int i = 0; i < RC_C + 4; i++) begin rand_inputs(); step(); end
        rand_inputs(); sim_rev_valid = 1'b1; fin = 1'b1;
        step();
        for (int i = 0; i < 12; i++) begin rand_inputs(); step(); end

        // Early fin pulsed during the reset hold
        async_reset();
        rand_inputs(); fin = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin rand_inputs(); step(); end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
